// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY logical-layer types, symbol constants and scrambler LFSR helpers.
package pcie_phy_pkg;

  typedef enum logic [2:0] {
    Gen1 = 3'd0,
    Gen2 = 3'd1,
    Gen3 = 3'd2,
    Gen4 = 3'd3,
    Gen5 = 3'd4
  } rate_speed_e;

  // Gen3+ block type latched at each block start.
  typedef enum logic [1:0] {
    BlkData,
    BlkOs,
    BlkBad
  } blk_type_e;

  localparam logic [7:0]  COM_SYM   = 8'hBC;
  localparam logic [7:0]  SKP_SYM   = 8'h1C;
  localparam logic [7:0]  SKP_OS_ID = 8'hAA;
  localparam logic [7:0]  EIEOS_ID  = 8'h00;
  localparam logic [15:0] GEN1_SEED = 16'hFFFF;

  localparam logic [22:0] GEN3_LANE_SEED [8] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  // Galois form of x^16+x^5+x^4+x^3+1; output bit is the MSB, data LSB first.
  function automatic logic [15:0] lfsr8b_step(input logic [15:0] s);
    return {s[14:0], s[15]} ^ (s[15] ? 16'h0038 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr8b_advance(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = lfsr8b_step(r);
    return r;
  endfunction

  function automatic logic [7:0] lfsr8b_key(input logic [15:0] s);
    logic [15:0] r;
    logic [7:0]  k;
    r = s;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[15];
      r    = lfsr8b_step(r);
    end
    return k;
  endfunction

  // Galois form of x^23+x^21+x^16+x^8+x^5+x^2+1.
  function automatic logic [22:0] lfsr128b_step(input logic [22:0] s);
    return {s[21:0], s[22]} ^ (s[22] ? 23'h210124 : 23'h000000);
  endfunction

  function automatic logic [22:0] lfsr128b_advance(input logic [22:0] s);
    logic [22:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = lfsr128b_step(r);
    return r;
  endfunction

  function automatic logic [7:0] lfsr128b_key(input logic [22:0] s);
    logic [22:0] r;
    logic [7:0]  k;
    r = s;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[22];
      r    = lfsr128b_step(r);
    end
    return k;
  endfunction

endpackage

// File: rtl/descramble_lane.sv
// One lane of the receive descrambler: Gen1/2 and Gen3+ LFSRs plus block state.
module descramble_lane
  import pcie_phy_pkg::*;
#(
  parameter int unsigned BYTES_PER_LANE = 4,
  parameter logic [22:0] SEED           = 23'h1DBFBC
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        gen3_i,
  input  logic                        rate_change_i,
  input  logic                        descramble_disable_i,
  input  logic [BYTES_PER_LANE*8-1:0] data_i,
  input  logic [BYTES_PER_LANE-1:0]   data_k_i,
  input  logic                        valid_i,
  input  logic                        block_start_i,
  input  logic [1:0]                  sync_header_i,
  output logic [BYTES_PER_LANE*8-1:0] data_o,
  output logic [BYTES_PER_LANE-1:0]   data_k_o,
  output logic                        data_valid_o,
  output logic                        block_start_o,
  output logic [1:0]                  sync_header_o
);

  logic [15:0] lfsr16_q, lfsr16_d;
  logic [22:0] lfsr23_q, lfsr23_d;
  blk_type_e   blk_q, blk_d;
  logic        skp_hold_q, skp_hold_d;
  logic        eieos_pend_q, eieos_pend_d;

  logic [BYTES_PER_LANE*8-1:0] data_q, data_d;
  logic [BYTES_PER_LANE-1:0]   k_q;
  logic                        valid_q, bs_q;
  logic [1:0]                  sh_q;

  // Working copies advanced symbol by symbol through the beat.
  logic [15:0] l16;
  logic [22:0] l23;
  blk_type_e   blk;
  logic        hold;
  logic        pend;
  logic [7:0]  sym;

  // Walk the beat LSB symbol first, updating LFSR/block state and descrambling.
  always_comb begin
    // A rate change reseeds before any symbol of this beat is processed.
    l16    = rate_change_i ? GEN1_SEED : lfsr16_q;
    l23    = rate_change_i ? SEED : lfsr23_q;
    blk    = rate_change_i ? BlkData : blk_q;
    hold   = rate_change_i ? 1'b0 : skp_hold_q;
    pend   = rate_change_i ? 1'b0 : eieos_pend_q;
    sym    = 8'h00;
    data_d = data_i;
    if (valid_i) begin
      if (gen3_i) begin
        if (block_start_i) begin
          // Pending EIEOS reseed lands before the first symbol of the new block.
          if (pend) l23 = SEED;
          pend = 1'b0;
          hold = 1'b0;
          unique case (sync_header_i)
            2'b10: blk = BlkData;
            2'b01: begin
              blk = BlkOs;
              if (data_i[7:0] == SKP_OS_ID) hold = 1'b1;
              else if (data_i[7:0] == EIEOS_ID) pend = 1'b1;
            end
            default: blk = BlkBad;
          endcase
        end
        for (int b = 0; b < int'(BYTES_PER_LANE); b++) begin
          sym = data_i[b*8 +: 8];
          if (blk == BlkData) data_d[b*8 +: 8] = sym ^ lfsr128b_key(l23);
          if (!hold) l23 = lfsr128b_advance(l23);
        end
      end else begin
        for (int b = 0; b < int'(BYTES_PER_LANE); b++) begin
          sym = data_i[b*8 +: 8];
          if (data_k_i[b] && (sym == COM_SYM)) begin
            l16 = GEN1_SEED;
          end else if (data_k_i[b] && (sym == SKP_SYM)) begin
            l16 = l16;
          end else if (data_k_i[b]) begin
            l16 = lfsr8b_advance(l16);
          end else begin
            data_d[b*8 +: 8] = sym ^ lfsr8b_key(l16);
            l16 = lfsr8b_advance(l16);
          end
        end
      end
    end
    if (descramble_disable_i) data_d = data_i;
    lfsr16_d     = l16;
    lfsr23_d     = l23;
    blk_d        = blk;
    skp_hold_d   = hold;
    eieos_pend_d = pend;
  end

  // State and one-cycle output pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr16_q     <= GEN1_SEED;
      lfsr23_q     <= SEED;
      blk_q        <= BlkData;
      skp_hold_q   <= 1'b0;
      eieos_pend_q <= 1'b0;
      data_q       <= '0;
      k_q          <= '0;
      valid_q      <= 1'b0;
      bs_q         <= 1'b0;
      sh_q         <= 2'b00;
    end else begin
      lfsr16_q     <= lfsr16_d;
      lfsr23_q     <= lfsr23_d;
      blk_q        <= blk_d;
      skp_hold_q   <= skp_hold_d;
      eieos_pend_q <= eieos_pend_d;
      data_q       <= data_d;
      k_q          <= data_k_i;
      valid_q      <= valid_i;
      bs_q         <= block_start_i;
      sh_q         <= sync_header_i;
    end
  end

  assign data_o        = data_q;
  assign data_k_o      = k_q;
  assign data_valid_o  = valid_q;
  assign block_start_o = bs_q;
  assign sync_header_o = sh_q;

endmodule

// File: rtl/pipe_multilane_descrambler.sv
// Multi-lane PIPE receive descrambler: lane slicing and link-rate change detect.
module pipe_multilane_descrambler
  import pcie_phy_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned BYTES_PER_LANE = 4,
  parameter int unsigned LANE_OFFSET    = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  rate_speed_e                           curr_data_rate_i,
  input  logic                                  descramble_disable_i,
  input  logic [NUM_LANES*BYTES_PER_LANE*8-1:0] data_in_i,
  input  logic [NUM_LANES*BYTES_PER_LANE-1:0]   data_k_in_i,
  input  logic [NUM_LANES-1:0]                  data_valid_i,
  input  logic [NUM_LANES-1:0]                  block_start_i,
  input  logic [2*NUM_LANES-1:0]                sync_header_i,
  output logic [NUM_LANES*BYTES_PER_LANE*8-1:0] data_out_o,
  output logic [NUM_LANES*BYTES_PER_LANE-1:0]   data_k_out_o,
  output logic [NUM_LANES-1:0]                  data_valid_o,
  output logic [NUM_LANES-1:0]                  block_start_o,
  output logic [2*NUM_LANES-1:0]                sync_header_o
);

  localparam int unsigned LaneBits = BYTES_PER_LANE * 8;

  rate_speed_e rate_q, rate_d;
  logic        rate_change;
  logic        gen3;

  // Track the rate seen last cycle so any change can reseed the lanes.
  always_comb begin
    rate_d = curr_data_rate_i;
  end

  // Rate register; reset value matches the Gen1 default of the lanes.
  always_ff @(posedge clk_i) begin
    if (rst_i) rate_q <= Gen1;
    else       rate_q <= rate_d;
  end

  assign rate_change = (curr_data_rate_i != rate_q);
  assign gen3        = (curr_data_rate_i >= Gen3);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    localparam int unsigned SeedIdx = (n + LANE_OFFSET) % 8;

    descramble_lane #(
      .BYTES_PER_LANE (BYTES_PER_LANE),
      .SEED           (GEN3_LANE_SEED[SeedIdx])
    ) u_lane (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .gen3_i               (gen3),
      .rate_change_i        (rate_change),
      .descramble_disable_i (descramble_disable_i),
      .data_i               (data_in_i[n*LaneBits +: LaneBits]),
      .data_k_i             (data_k_in_i[n*BYTES_PER_LANE +: BYTES_PER_LANE]),
      .valid_i              (data_valid_i[n]),
      .block_start_i        (block_start_i[n]),
      .sync_header_i        (sync_header_i[2*n +: 2]),
      .data_o               (data_out_o[n*LaneBits +: LaneBits]),
      .data_k_o             (data_k_out_o[n*BYTES_PER_LANE +: BYTES_PER_LANE]),
      .data_valid_o         (data_valid_o[n]),
      .block_start_o        (block_start_o[n]),
      .sync_header_o        (sync_header_o[2*n +: 2])
    );
  end

endmodule

// File: tb/tb_pipe_multilane_descrambler.sv
// Self-checking bench: directed test-plan steps followed by randomized beats,
// all checked against a bit-serial polynomial reference model.
module tb_pipe_multilane_descrambler;
  import pcie_phy_pkg::*;

  localparam int NL   = 4;
  localparam int BPL  = 4;
  localparam int LOFF = 4;

  localparam logic [22:0] SEEDS [8] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  logic              clk = 1'b0;
  logic              rst;
  rate_speed_e       rate;
  logic              dis;
  logic [NL*BPL*8-1:0] din;
  logic [NL*BPL-1:0] kin;
  logic [NL-1:0]     vin, bsin;
  logic [2*NL-1:0]   shin;
  logic [NL*BPL*8-1:0] data_out;
  logic [NL*BPL-1:0] k_out;
  logic [NL-1:0]     v_out, bs_out;
  logic [2*NL-1:0]   sh_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [15:0] m16 [NL];
  logic [22:0] m23 [NL];
  int          mblk [NL];   // 0 data, 1 ordered set, 2 invalid header
  bit          mhold [NL];
  bit          mpend [NL];
  rate_speed_e mrate;
  int          bcnt [NL];

  always #5 clk = ~clk;

  pipe_multilane_descrambler #(
    .NUM_LANES      (NL),
    .BYTES_PER_LANE (BPL),
    .LANE_OFFSET    (LOFF)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .curr_data_rate_i     (rate),
    .descramble_disable_i (dis),
    .data_in_i            (din),
    .data_k_in_i          (kin),
    .data_valid_i         (vin),
    .block_start_i        (bsin),
    .sync_header_i        (shin),
    .data_out_o           (data_out),
    .data_k_out_o         (k_out),
    .data_valid_o         (v_out),
    .block_start_o        (bs_out),
    .sync_header_o        (sh_out)
  );

  // One byte of Gen1/2 keystream as polynomial arithmetic: returns {next_state, key}.
  function automatic logic [23:0] g1(input logic [15:0] s);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    end
    return {s, k};
  endfunction

  // One byte of Gen3 keystream: returns {next_state, key}.
  function automatic logic [30:0] g3(input logic [22:0] s);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[22];
      s = {s[21:0], 1'b0} ^ (s[22] ? 23'h210125 : 23'h000000);
    end
    return {s, k};
  endfunction

  // First four Gen3 key bytes starting from a seed, packed LSB byte first.
  function automatic logic [31:0] ks4(input logic [22:0] seed);
    logic [31:0] w;
    logic [30:0] r;
    for (int b = 0; b < 4; b++) begin
      r = g3(seed);
      w[b*8 +: 8] = r[7:0];
      seed = r[30:8];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m16[l]   = 16'hFFFF;
      m23[l]   = SEEDS[(l + LOFF) % 8];
      mblk[l]  = 0;
      mhold[l] = 0;
      mpend[l] = 0;
      bcnt[l]  = 0;
    end
    mrate = Gen1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict this beat from the model, clock it, then compare all outputs.
  task automatic step();
    logic [NL*BPL*8-1:0] ed;
    logic [NL*BPL-1:0]   ek;
    logic [NL-1:0]       ev, eb;
    logic [2*NL-1:0]     es;
    logic [7:0]          sy;
    logic [23:0]         r1;
    logic [30:0]         r3;
    bit                  rc;
    if (rst) begin
      ed = '0; ek = '0; ev = '0; eb = '0; es = '0;
      model_reset();
    end else begin
      ed = din; ek = kin; ev = vin; eb = bsin; es = shin;
      rc = (rate != mrate);
      mrate = rate;
      for (int l = 0; l < NL; l++) begin
        if (rc) begin
          m16[l] = 16'hFFFF; m23[l] = SEEDS[(l + LOFF) % 8];
          mblk[l] = 0; mhold[l] = 0; mpend[l] = 0;
        end
        if (!vin[l]) continue;
        if (rate >= Gen3) begin
          if (bsin[l]) begin
            if (mpend[l]) m23[l] = SEEDS[(l + LOFF) % 8];
            mpend[l] = 0;
            mhold[l] = 0;
            case (shin[2*l +: 2])
              2'b10: mblk[l] = 0;
              2'b01: begin
                mblk[l] = 1;
                sy = din[l*32 +: 8];
                if (sy == 8'hAA) mhold[l] = 1;
                else if (sy == 8'h00) mpend[l] = 1;
              end
              default: mblk[l] = 2;
            endcase
          end
          for (int b = 0; b < BPL; b++) begin
            r3 = g3(m23[l]);
            if (mblk[l] == 0) ed[l*32 + b*8 +: 8] = din[l*32 + b*8 +: 8] ^ r3[7:0];
            if (!mhold[l]) m23[l] = r3[30:8];
          end
        end else begin
          for (int b = 0; b < BPL; b++) begin
            sy = din[l*32 + b*8 +: 8];
            r1 = g1(m16[l]);
            if (kin[l*BPL + b] && sy == 8'hBC)      m16[l] = 16'hFFFF;
            else if (kin[l*BPL + b] && sy == 8'h1C) m16[l] = m16[l];
            else if (kin[l*BPL + b])                m16[l] = r1[23:8];
            else begin
              ed[l*32 + b*8 +: 8] = sy ^ r1[7:0];
              m16[l] = r1[23:8];
            end
          end
        end
      end
      if (dis) ed = din;
    end
    @(posedge clk);
    #1;
    chk("data", data_out, ed);
    chk("k", k_out, ek);
    chk("valid", v_out, ev);
    chk("block_start", bs_out, eb);
    chk("sync_header", sh_out, es);
  endtask

  task automatic set_all(input logic [31:0] d, input logic [3:0] k, input bit bs,
                         input logic [1:0] sh);
    din  = {NL{d}};
    kin  = {NL{k}};
    vin  = '1;
    bsin = {NL{bs}};
    shin = {NL{sh}};
  endtask

  initial begin
    logic [7:0]  sy;
    logic [1:0]  sh;
    int          pick;
    model_reset();
    rst = 1'b1; rate = Gen1; dis = 1'b0;
    set_all(32'h0, 4'h0, 1'b0, 2'b10);
    vin = '0;
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;

    // Gen1: COM then the known keystream bytes descramble to zero.
    set_all(32'hC017FFBC, 4'b0001, 1'b0, 2'b00); step();
    chk("g1_com_beat", data_out[31:0], 32'h000000BC);
    set_all(32'h02E7B214, 4'b0000, 1'b0, 2'b00); step();
    chk("g1_d_beat", data_out[31:0], 32'h0);
    set_all(32'h00000082, 4'b0000, 1'b0, 2'b00); step();
    chk("g1_d_tail", data_out[7:0], 8'h00);

    // Gen1: LFSR holds across two SKPs split over beats.
    set_all(32'h1C17FFBC, 4'b1001, 1'b0, 2'b00); step();
    chk("g1_skp_a", data_out[31:0], 32'h1C0000BC);
    set_all(32'hB214C01C, 4'b0001, 1'b0, 2'b00); step();
    chk("g1_skp_b", data_out[31:0], 32'h0000001C);

    // Gen1 -> Gen3 mid-stream: zero data block gives each lane's seed keystream.
    rate = Gen3;
    set_all(32'h0, 4'h0, 1'b1, 2'b10); step();
    for (int l = 0; l < NL; l++) chk("g3_seed_ks", data_out[l*32 +: 32], ks4(SEEDS[(l + LOFF) % 8]));
    set_all(32'h0, 4'h0, 1'b0, 2'b10);
    repeat (3) step();

    // SKP OS of variable length, then a data block.
    set_all(32'hAAAAAAAA, 4'h0, 1'b1, 2'b01); step();
    chk("g3_skp_os_pass", data_out, {NL{32'hAAAAAAAA}});
    set_all(32'hAAAAAAAA, 4'h0, 1'b0, 2'b01); step();
    set_all(32'h0, 4'h0, 1'b1, 2'b10); step();
    set_all(32'h0, 4'h0, 1'b0, 2'b10);
    repeat (3) step();

    // EIEOS, then the next data block restarts from the lane seed.
    set_all(32'hFFFFFF00, 4'h0, 1'b1, 2'b01); step();
    chk("g3_eieos_pass", data_out, {NL{32'hFFFFFF00}});
    set_all(32'hFFFFFFFF, 4'h0, 1'b0, 2'b01);
    repeat (3) step();
    set_all(32'h0, 4'h0, 1'b1, 2'b10); step();
    for (int l = 0; l < NL; l++) chk("g3_eieos_reseed", data_out[l*32 +: 32], ks4(SEEDS[(l + LOFF) % 8]));

    // Gen3 -> Gen1 mid-block: Gen1 LFSR restarts at FFFF.
    rate = Gen1;
    set_all(32'h0, 4'h0, 1'b0, 2'b00); step();
    chk("g1_rate_reseed", data_out[31:0], 32'h14C017FF);

    // Reset in the middle of an ordered set; no stale block type afterwards.
    rate = Gen3;
    set_all(32'h00000055, 4'h0, 1'b1, 2'b01); step();
    set_all(32'h0, 4'h0, 1'b0, 2'b01);
    rst = 1'b1; step();
    chk("rst_data_zero", data_out, '0);
    chk("rst_valid_zero", v_out, '0);
    rst = 1'b0;
    set_all(32'h0, 4'h0, 1'b0, 2'b01); step();
    for (int l = 0; l < NL; l++) chk("rst_reseed", data_out[l*32 +: 32], ks4(SEEDS[(l + LOFF) % 8]));

    // Randomized traffic.
    for (int l = 0; l < NL; l++) bcnt[l] = 0;
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 49) == 0) rate = rate_speed_e'($urandom_range(0, 4));
      dis = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      for (int l = 0; l < NL; l++) begin
        vin[l]  = ($urandom_range(0, 4) != 0);
        bsin[l] = 1'b0;
        sh      = 2'b10;
        for (int b = 0; b < BPL; b++) begin
          pick = $urandom_range(0, 15);
          sy   = 8'($urandom);
          kin[l*BPL + b] = 1'b0;
          if (rate < Gen3) begin
            if (pick < 2)      begin sy = 8'hBC; kin[l*BPL + b] = 1'b1; end
            else if (pick < 4) begin sy = 8'h1C; kin[l*BPL + b] = 1'b1; end
            else if (pick < 5) begin sy = 8'hF7; kin[l*BPL + b] = 1'b1; end
          end
          din[l*32 + b*8 +: 8] = sy;
        end
        if (rate >= Gen3 && vin[l]) begin
          if (bcnt[l] % 4 == 0) begin
            bsin[l] = 1'b1;
            pick = $urandom_range(0, 7);
            if (pick < 4)      sh = 2'b10;
            else if (pick < 7) sh = 2'b01;
            else               sh = 2'($urandom_range(0, 1) * 3);
            pick = $urandom_range(0, 2);
            if (sh == 2'b01 && pick == 0) din[l*32 +: 8] = 8'hAA;
            if (sh == 2'b01 && pick == 1) din[l*32 +: 8] = 8'h00;
          end
          bcnt[l]++;
        end
        shin[2*l +: 2] = sh;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_multilane_descrambler.md
# pipe_multilane_descrambler

Parametrised multi-lane receive descrambler for the PCIe PHY logical layer. It sits between the per-lane block/symbol aligners and the lane deskew/ordered-set decoder. For each lane it keeps an independent LFSR and handles both encodings: 8b/10b (Gen1/Gen2), with COM reset and SKP hold, and 128b/130b (Gen3+), with per-lane seeds, ordered-set bypass, EIEOS reseed and SKP-OS hold.

## Interface
Parameters:
- `NUM_LANES`, 4: lanes processed in parallel.
- `BYTES_PER_LANE`, 4: symbols per lane per cycle; legal values 1, 2, 4.
- `LANE_OFFSET`, 0: physical lane number of lane 0, used for Gen3 seed selection.

Ports:
- `clk_i` in 1: PIPE clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `curr_data_rate_i` in `rate_speed_e`: current link rate.
- `descramble_disable_i` in 1: pass data through unchanged; LFSRs still advance.
- `data_in_i` in `NUM_LANES*BYTES_PER_LANE*8`: lane-major; lane n occupies bits `[n*BPL*8 +: BPL*8]`.
- `data_k_in_i` in `NUM_LANES*BYTES_PER_LANE`: K flag per symbol (Gen1/2).
- `data_valid_i` in `NUM_LANES`: per-lane valid.
- `block_start_i` in `NUM_LANES`: first beat of a 130b block (Gen3).
- `sync_header_i` in `2*NUM_LANES`: 2'b10 = data block, 2'b01 = ordered set; sampled on `block_start_i`.
- `data_out_o` out `NUM_LANES*BYTES_PER_LANE*8`: descrambled data.
- `data_k_out_o` out `NUM_LANES*BYTES_PER_LANE`: delayed K flags.
- `data_valid_o` out `NUM_LANES`: delayed valid.
- `block_start_o` out `NUM_LANES`: delayed block start.
- `sync_header_o` out `2*NUM_LANES`: delayed sync header.

## Operation
- Each lane is fully independent. Symbols within a beat are processed LSB byte first; the LFSR advances 8 steps per processed symbol.
- Gen1/2 (`curr_data_rate_i < gen3`): LFSR x^16+x^5+x^4+x^3+1, seed 16'hFFFF.
  - COM (K, 8'hBC): LFSR reloads the seed; symbol passed unscrambled.
  - SKP (K, 8'h1C): LFSR holds; symbol passed unscrambled.
  - Other K symbols: passed unscrambled; LFSR advances.
  - D symbols: XOR with the LFSR output byte; LFSR advances.
  - The reset/hold takes effect for the next symbol in the same beat.
- Gen3+: LFSR x^23+x^21+x^16+x^8+x^5+x^2+1.
  - Seed for physical lane `(n+LANE_OFFSET) mod 8`: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807.
  - Block type is latched on `block_start_i` from `sync_header_i`.
  - Data block: every symbol is descrambled; LFSR advances.
  - Ordered set: symbols pass unscrambled.
    - First symbol 8'hAA (SKP OS): LFSR holds for the whole block. SKP OS length is variable; the hold lasts until the next `block_start_i`.
    - First symbol 8'h00 (EIEOS): LFSR advances through the block, then reloads the lane seed on the next `block_start_i`.
    - Any other OS: LFSR advances.
  - Invalid sync header (00/11): data passed unscrambled, LFSR advances.
- `data_valid_i` low: LFSR and all lane state hold.
- `descramble_disable_i`: output equals input; LFSR updates unchanged.
- Any change of `curr_data_rate_i` (registered compare) reloads every LFSR with the seed for the new rate. This takes effect in the same cycle the change is seen and has priority over the data of that beat.

## Timing
- Latency is exactly 1 cycle for all outputs. Data, K, valid, block_start and sync_header leave aligned on the same edge.
- Reset values: all outputs 0. Gen1 LFSRs 16'hFFFF. Gen3 LFSRs set to their lane seeds. Block-type state is "data". Pending-EIEOS flag 0.
- Reset asserted mid-block: state is reseeded on the next edge, and the partial block is discarded (valid_o 0).
- Simultaneous COM and SKP in one beat: handled in symbol order.
- Simultaneous `block_start_i` and pending EIEOS reseed: the reseed is applied before the first symbol of the new block is processed.

## Structure
- `pcie_phy_pkg` holds:
  - the two polynomials' next-byte functions `lfsr8b_advance` and `lfsr128b_advance`;
  - the `GEN3_LANE_SEED[8]` constant array;
  - `COM_SYM`, `SKP_SYM`, `SKP_OS_ID`, `EIEOS_ID`;
  - the existing `rate_speed_e`.
- Sub-module `descramble_lane`: one lane, `BYTES_PER_LANE` and a `SEED` parameter, generated `NUM_LANES` times. The top level only does slicing and the rate-change detect.

## Test plan
- Gen1, lane 0: COM, then D bytes FF 17 C0 14 B2 E7 02 82 → output BC(K), 00×8.
- Gen1: COM, FF 17, SKP, SKP, C0 14 → output 00 00, 1C 1C unchanged, 00 00. Confirms the LFSR held across SKP.
- Gen3, 4 lanes with `LANE_OFFSET`=4: after reset each lane's LFSR equals 010F12, 19CFC9, 0277CE, 1BB807. A data block of zeros yields that lane's scrambling keystream, matching the package model.
- Gen3: data block, SKP OS (AA…), data block → LFSR state after the SKP OS equals the state before it. SKP bytes output unchanged.
- Gen3: data block, EIEOS (00 FF…), data block → first byte of the following block is descrambled with the seed (LFSR == lane seed at block_start).
- Rate change Gen1→Gen3 mid-stream and `rst_i` mid-block → all LFSRs reseed. Outputs are 0 the cycle after reset. No stale block-type state.
